// File: rtl/turbo_deinterleaver.sv
// Block de-interleaver: bits are written to an internal RAM at the address
// given by an external permutation ROM, then read back in natural order.
module turbo_deinterleaver (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_bit,
   input  logic        in_valid,
   input  logic        K,
   output logic        in_ready,
   output logic [13:0] rom_addr,
   input  logic [12:0] pi,
   output logic        out_bit,
   output logic        out_valid,
   output logic        out_last,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, FILL, FLUSH, DRAIN} state_t;

   state_t      state, state_nxt;
   logic        k_lat, k_eff;
   logic [12:0] len, len_m1;
   logic [12:0] wr_count, rd_count;
   logic        accept;
   logic        wr_pend, wr_bit;
   logic        rd_q;
   logic        mem [0:8191];

   // Block size follows the live K input only until the first beat is taken.
   assign k_eff    = (state == IDLE) ? K : k_lat;
   assign len      = k_eff ? 13'd6144 : 13'd1056;
   assign len_m1   = len - 13'd1;
   assign in_ready = (state == IDLE) || (state == FILL);
   assign accept   = in_valid && in_ready;
   assign rom_addr = {k_eff, wr_count};
   assign out_bit  = rd_q & out_valid;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = FILL;
         FILL:    if (accept && wr_count == len_m1) state_nxt = FLUSH;
         FLUSH:   state_nxt = DRAIN;
         DRAIN:   if (rd_count == len_m1) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         k_lat     <= 1'b0;
         wr_count  <= '0;
         rd_count  <= '0;
         wr_pend   <= 1'b0;
         wr_bit    <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         err       <= 1'b0;
      end else begin
         state   <= state_nxt;
         wr_pend <= accept;
         if (accept) begin
            wr_bit   <= in_bit;
            wr_count <= (wr_count == len_m1) ? '0 : wr_count + 13'd1;
         end
         if (state == IDLE && accept)
            k_lat <= K;
         if (state == DRAIN)
            rd_count <= (rd_count == len_m1) ? '0 : rd_count + 13'd1;
         out_valid <= (state == DRAIN);
         out_last  <= (state == DRAIN) && (rd_count == len_m1);
         // ROM data arrives one cycle after its address, alongside the held bit.
         if (wr_pend && pi >= len)
            err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_pend && !reset && pi < len)
         mem[pi] <= wr_bit;
      rd_q <= mem[rd_count];
   end

endmodule

// File: tb/tb_turbo_deinterleaver.sv
// Randomized bench: a behavioural bit-array model de-interleaves each block
// and the collected output stream is compared against it.
module tb_turbo_deinterleaver;

   logic        clk = 1'b0;
   logic        reset, in_bit, in_valid, K;
   logic        in_ready, out_bit, out_valid, out_last, err;
   logic [13:0] rom_addr;
   logic [12:0] pi;

   turbo_deinterleaver dut (
      .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid), .K(K),
      .in_ready(in_ready), .rom_addr(rom_addr), .pi(pi), .out_bit(out_bit),
      .out_valid(out_valid), .out_last(out_last), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int total = 0, bad = 0;
   int rom_mode = 0;
   bit bad_en = 1'b0;
   int bad_idx = 0;

   function automatic int perm(int mode, int len, int i);
      case (mode)
         0:       return i;
         1:       return len - 1 - i;
         default: return (13 * i + 5) % len;
      endcase
   endfunction

   function automatic int rom_val(int mode, int len, int i);
      if (bad_en && i == bad_idx) return 2000;
      return perm(mode, len, i);
   endfunction

   always @(posedge clk)
      pi <= 13'(rom_val(rom_mode, rom_addr[13] ? 6144 : 1056, int'(rom_addr[12:0])));

   bit ob [0:32767];
   bit ol [0:32767];
   int oc [0:32767];
   int out_n = 0;
   int nready = 0;

   always @(negedge clk) begin
      if (out_valid === 1'b1 && out_n < 32768) begin
         ob[out_n] = out_bit;
         ol[out_n] = out_last;
         oc[out_n] = cyc;
         out_n++;
      end
      if (in_ready === 1'b0) nready++;
   end

   bit mm [0:8191];
   bit expb [0:1][0:6143];
   int explen [0:1];
   int tfirst [0:1];
   int tlast [0:1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, want);
      end
   endtask

   task automatic send_block(input int slot, input bit k, input int mode, input bit gap,
                             input int bad_i, input int abort_at, input bit rnd);
      int  len, i, guard, p, tcur;
      bit  b;
      logic rdy;
      len = k ? 6144 : 1056;
      i = 0;
      guard = 0;
      rom_mode = mode;
      bad_en = (bad_i >= 0);
      bad_idx = bad_i;
      while (i < len && i != abort_at) begin
         b = rnd ? 1'($urandom_range(1, 0)) : i[0];
         in_bit = b;
         in_valid = 1'b1;
         K = k;
         rdy = in_ready;
         tcur = cyc;
         @(posedge clk); #1;
         if (rdy === 1'b1) begin
            if (i == 0) tfirst[slot] = tcur;
            tlast[slot] = tcur;
            p = rom_val(mode, len, i);
            if (p < len) mm[p] = b;
            i++;
            if (gap) begin
               in_valid = 1'b0;
               @(posedge clk); #1;
            end
         end
         guard++;
         if (guard > 20000) begin
            chk("send_timeout", 0, 1);
            break;
         end
      end
      in_valid = 1'b0;
      for (int j = 0; j < len; j++) expb[slot][j] = mm[j];
      explen[slot] = len;
   endtask

   task automatic check_block(input int slot, input int start);
      int len, guard, mism, lastbad, gapbad;
      len = explen[slot];
      guard = 0;
      while (out_n < start + len && guard < len + 100) begin
         @(negedge clk);
         guard++;
      end
      chk("out_count_reached", out_n >= start + len, 1);
      if (out_n < start + len) return;
      mism = 0; lastbad = 0; gapbad = 0;
      for (int j = 0; j < len; j++) begin
         if (ob[start + j] != expb[slot][j]) mism++;
         if (ol[start + j] != (j == len - 1)) lastbad++;
         if (j > 0 && oc[start + j] != oc[start + j - 1] + 1) gapbad++;
      end
      chk("data_mismatches", mism, 0);
      chk("last_flag_errors", lastbad, 0);
      chk("valid_gaps", gapbad, 0);
      chk("latency_first", oc[start], tlast[slot] + 3);
      chk("latency_last", oc[start + len - 1], tlast[slot] + 2 + len);
   endtask

   int s, nr;

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; K = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_bit", out_bit, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_err", err, 0);
      chk("rst_rom_addr_k0", rom_addr, 14'h0000);
      reset = 1'b0;
      K = 1'b1; #1;
      chk("idle_rom_addr_k1", rom_addr, 14'h2000);
      K = 1'b0;
      @(posedge clk); #1;

      // identity, K=0, in_bit = i[0]
      s = out_n;
      send_block(0, 1'b0, 0, 1'b0, -1, -1, 1'b0);
      check_block(0, s);
      repeat (5) @(negedge clk);
      chk("no_extra_A", out_n, s + 1056);
      chk("idle_ready_A", in_ready, 1);

      // reversed, K=1, random bits
      s = out_n; nr = nready;
      send_block(0, 1'b1, 1, 1'b0, -1, -1, 1'b1);
      check_block(0, s);
      chk("ready_low_cycles_B", nready - nr, 6145);

      // affine permutation with input gaps
      @(posedge clk); #1;
      s = out_n;
      send_block(0, 1'b0, 2, 1'b1, -1, -1, 1'b1);
      check_block(0, s);
      repeat (5) @(negedge clk);
      chk("no_extra_C", out_n, s + 1056);

      // out-of-range pi on beat 100: write dropped, err sticky
      @(posedge clk); #1;
      chk("err_before_D", err, 0);
      s = out_n;
      send_block(0, 1'b0, 0, 1'b0, 100, -1, 1'b1);
      check_block(0, s);
      repeat (5) @(posedge clk);
      #1;
      chk("err_sticky_D", err, 1);
      bad_en = 1'b0;

      // abort at beat 500 with reset
      s = out_n;
      send_block(0, 1'b0, 2, 1'b0, -1, 500, 1'b1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_err_cleared", err, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("abort_no_output", out_n, s);
      send_block(0, 1'b0, 2, 1'b0, -1, -1, 1'b1);
      check_block(0, s);

      // back-to-back K=0 then K=1
      @(posedge clk); #1;
      s = out_n;
      send_block(0, 1'b0, 0, 1'b0, -1, -1, 1'b1);
      send_block(1, 1'b1, 1, 1'b0, -1, -1, 1'b1);
      chk("b2b_first_accept", tfirst[1], tlast[0] + 2 + 1056);
      check_block(0, s);
      check_block(1, s + 1056);
      repeat (5) @(negedge clk);
      chk("no_extra_b2b", out_n, s + 1056 + 6144);
      chk("err_final", err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/turbo_deinterleaver.md
TURBO_DEINTERLEAVER -- requirements
Module: turbo_deinterleaver

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port in_bit, input, 1, interleaved code bit c'(i).
REQ-004 SHALL have port in_valid, input, 1, in_bit valid; accepted only when in_ready=1.
REQ-005 SHALL have port K, input, 1, block size select: 0 -> 1056 bits, 1 -> 6144 bits.
REQ-006 SHALL have port in_ready, output, 1, high only in IDLE and FILL.
REQ-007 SHALL have port rom_addr, output, 14, {k_eff, wr_count} to the external synchronous permutation ROM.
REQ-008 SHALL have port pi, input, 13, ROM data; 1-cycle read latency after rom_addr.
REQ-009 SHALL have port out_bit, output, 1, de-interleaved bit c(j) in natural order.
REQ-010 SHALL have port out_valid, output, 1, out_bit valid; no backpressure.
REQ-011 SHALL have port out_last, output, 1, high with final bit j=len-1.
REQ-012 SHALL have port err, output, 1, sticky flag for pi >= len.

Function
REQ-013 SHALL contain an internal 8192x1 RAM, 1-cycle read latency, write-first not relied upon.
REQ-014 SHALL implement states IDLE, FILL, FLUSH, DRAIN.
REQ-015 k_eff SHALL equal K in IDLE and the value latched on the first accepted beat otherwise; len = 1056 or 6144 from k_eff.
REQ-016 IDLE: accepted beat -> latch K, wr_count 0->1, go FILL; if len would be 1, never happens (len >= 1056).
REQ-017 Each accepted beat SHALL present rom_addr={k_eff, wr_count} same cycle and register in_bit; next cycle RAM[pi] <= registered bit.
REQ-018 wr_count SHALL increment only on accepted beats; in_valid=0 cycles insert gaps with no write and no count change.
REQ-019 Beat accepted with wr_count=len-1 SHALL move to FLUSH next cycle; FLUSH performs that final write, then DRAIN.
REQ-020 in_ready SHALL be 0 in FLUSH and DRAIN; in_valid there ignored.
REQ-021 DRAIN: rd_count 0..len-1, one RAM read per cycle; out_valid/out_bit one cycle after each read; out_last with rd_count=len-1 data.
REQ-022 After read of len-1 issued, SHALL return to IDLE next cycle; trailing out_valid for len-1 occurs that IDLE cycle; a new beat may be accepted in that cycle.
REQ-023 Latency: last input accepted cycle t -> bit 0 out_valid at t+3; bit len-1 at t+2+len.
REQ-024 pi >= len SHALL suppress the write and set err; err cleared only by reset.
REQ-025 Unwritten RAM locations SHALL read whatever they hold; no clear between blocks.
REQ-026 Counters 13 bits, SHALL never wrap past len-1.

Reset
REQ-027 reset SHALL force IDLE, wr_count=rd_count=0, in_ready=1, out_valid=0, out_bit=0, out_last=0, err=0, suppress pending write; RAM contents undefined.
REQ-028 reset mid-FILL or mid-DRAIN SHALL abort the block; next block starts clean in IDLE.

Verification
REQ-029 K=0, identity pi, 1056 beats back-to-back, in_bit=i[0] -> out_bit j = j[0], first out_valid 3 cycles after last beat, out_last on j=1055.
REQ-030 K=1, pi(i)=6143-i, random bits -> output equals input reversed, 6144 valids contiguous, in_ready 0 from FLUSH to end of DRAIN.
REQ-031 K=0, in_valid toggled 1/0 every cycle -> 1056 writes only, output matches golden de-interleave, no extra outputs.
REQ-032 reset asserted at beat 500 of FILL -> in_ready=1, out_valid=0 next cycle; subsequent full block correct.
REQ-033 pi returns 2000 for one beat with K=0 -> err=1 sticky, no write; other bits correct.
REQ-034 Two blocks back-to-back (K=0 then K=1), second first beat in IDLE cycle after last read -> both outputs correct, K switch respected.
